digit_scan_ctrl: RTL and testbench
==================================

Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit hex display.
- Sits directly upstream of the 2-to-4 decoder: its 2-bit `sel` output drives the decoder input, and the decoder's one-hot output becomes the digit enables.
- Holds a 16-bit display value and steps through its nibbles at a programmable rate.
- Emits the current nibble and its 7-segment pattern.
- New values are accepted through a load handshake and applied only at frame boundaries, so a displayed frame is never torn.

Parameters:
- PRESCALE, 16: clock cycles per digit slot. Legal range 2..65535.
- CNT_W, 16: prescaler counter width. Must satisfy 2^CNT_W >= PRESCALE.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset_L  input  1  asynchronous, active-low reset.
- value_in  input  16  value to display; digit 0 = [3:0], digit 3 = [15:12].
- load  input  1  single-cycle request to capture value_in.
- blank_lz  input  1  1 = blank leading-zero digits.
- sel  output  2  current digit index; feeds the 2-to-4 decoder.
- nibble  output  4  hex nibble of the current digit.
- seg  output  7  active-high segments {g,f,e,d,c,b,a}; 0 when the digit is blanked.
- frame_done  output  1  one-cycle pulse on the final tick of digit 3.
- load_ack  output  1  one-cycle pulse when a captured value becomes the displayed value.

Behaviour:
- Reset (async assert, sync-free deassert): prescaler=0, sel=0, disp=0, shadow=0, pending=0, frame_done=0, load_ack=0.
  - Combinational outputs at reset: nibble=0, seg=7'h3F.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick = (prescaler == PRESCALE-1).
- sel:
  - Increments by 1 on each tick; wraps 3 -> 0.
  - Each sel value is held for exactly PRESCALE cycles.
- frame_done: registered; asserted for the one cycle after the edge where tick=1 and sel=3, i.e. coincident with sel returning to 0.
- Load path:
  - load=1 on an edge: shadow <= value_in, pending <= 1.
  - Multiple loads within one frame: only the last one is retained.
- Frame boundary (edge where tick=1 and sel=3), if pending=1:
  - disp <= shadow, pending <= 0, load_ack pulses the following cycle (same cycle as frame_done).
- Simultaneous load and frame boundary on the same edge:
  - disp takes the pre-edge shadow.
  - shadow takes value_in; pending stays 1.
  - The new value appears at the next boundary.
  - load_ack still pulses for the transfer that occurred.
- Boundary with pending=0: disp is unchanged and load_ack stays 0.
- nibble: combinational from registered state, disp[4*sel +: 4].
- seg: combinational hex decode of nibble:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Blanking:
  - Applies when blank_lz=1, sel=k>0, and disp[15:4k]==0; then seg=0.
  - nibble is unaffected by blanking.
  - Digit 0 is never blanked, so disp=0 shows "0".
  - blank_lz is sampled combinationally and takes effect immediately.
- Reset asserted mid-frame: all state clears immediately, and pending loads are discarded. After deassert, scanning restarts at sel=0 with prescaler=0.

Test Plan:
- Reset check (PRESCALE=4). Hold Reset_L=0 for 3 cycles, then release.
  - During reset: sel=0, seg=7'h3F, frame_done=0, load_ack=0.
  - After release: sel steps 0,1,2,3,0 every 4 cycles; frame_done pulses once every 16 cycles.
- Load and display. Pulse load with value_in=16'h1A2F mid-frame.
  - Digits are unchanged until the boundary.
  - load_ack and frame_done pulse together.
  - Next frame: nibble/seg per sel are 0:F/71, 1:2/5B, 2:A/77, 3:1/06.
- Last-load-wins. Load 16'h1111, then 16'h2222 within the same frame.
  - Next frame shows 2222 with a single load_ack.
- Load on boundary edge. With disp=0 and shadow pending 16'h00AB, pulse load=16'hCDEF on the boundary edge.
  - Next frame shows 00AB and load_ack=1.
  - The following frame shows CDEF with another load_ack.
- Leading-zero blanking. disp=16'h0005, blank_lz=1.
  - seg: sel0=6D, sel1=00, sel2=00, sel3=00.
  - disp=16'h0000: sel0=3F, others 00.
  - With blank_lz=0, every digit shows 3F.
- Reset mid-operation. Assert Reset_L with a load pending at sel=2.
  - Immediate clear: sel=0, nibble=0.
  - After release the value never appears and no load_ack pulses.

Source files
------------

// File: rtl/digit_scan_ctrl_if.sv
// Display scan bus: load handshake in, digit select and segments out.
// The driver side is master; the scan controller is slave.
interface digit_scan_ctrl_if;
  logic [15:0] value_in;
  logic        load;
  logic        blank_lz;
  logic [1:0]  sel;
  logic [3:0]  nibble;
  logic [6:0]  seg;
  logic        frame_done;
  logic        load_ack;

  modport master (
    output value_in, load, blank_lz,
    input  sel, nibble, seg, frame_done, load_ack
  );

  modport slave (
    input  value_in, load, blank_lz,
    output sel, nibble, seg, frame_done, load_ack
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// 4-digit hex scan controller: prescaled digit select, tear-free
// value updates at frame boundaries, 7-segment decode with LZ blanking.
module digit_scan_ctrl #(
  parameter int PRESCALE = 16,
  parameter int CNT_W    = 16
) (
  input logic              CLK,
  input logic              Reset_L,
  digit_scan_ctrl_if.slave bus
);

  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_sel;
  logic [15:0]      r_disp;
  logic [15:0]      r_shadow;
  logic             r_pending;
  logic             r_frame_done;
  logic             r_load_ack;

  logic             w_tick;
  logic             w_bound;
  logic [3:0]       w_nib;
  logic             w_lz;
  logic [6:0]       w_hex;

  assign w_tick  = (r_presc == CNT_W'(PRESCALE - 1));
  assign w_bound = w_tick && (r_sel == 2'd3);

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_presc      <= '0;
      r_sel        <= 2'd0;
      r_disp       <= 16'h0000;
      r_shadow     <= 16'h0000;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_load_ack   <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + CNT_W'(1);
      r_sel        <= r_sel + {1'b0, w_tick};
      r_frame_done <= w_bound;
      r_load_ack   <= w_bound && r_pending;
      // Transfer uses the pre-edge shadow; a same-edge load stays pending.
      if (w_bound && r_pending)
        r_disp <= r_shadow;
      if (bus.load) begin
        r_shadow  <= bus.value_in;
        r_pending <= 1'b1;
      end else if (w_bound) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_nib = 4'h0;
    w_lz  = 1'b0;
    unique case (r_sel)
      2'd0: begin
        w_nib = r_disp[3:0];
        w_lz  = 1'b0;
      end
      2'd1: begin
        w_nib = r_disp[7:4];
        w_lz  = (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib = r_disp[11:8];
        w_lz  = (r_disp[15:8] == 8'h00);
      end
      2'd3: begin
        w_nib = r_disp[15:12];
        w_lz  = (r_disp[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    w_hex = 7'h00;
    unique case (w_nib)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
    endcase
  end

  assign bus.sel        = r_sel;
  assign bus.nibble     = w_nib;
  assign bus.seg        = (bus.blank_lz && w_lz) ? 7'h00 : w_hex;
  assign bus.frame_done = r_frame_done;
  assign bus.load_ack   = r_load_ack;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: directed scenarios plus random loads,
// checked every cycle against a frame-timeline reference model.
module tb_digit_scan_ctrl;

  localparam int P  = 4;
  localparam int FR = 4 * P;

  localparam logic [6:0] SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic CLK;
  logic Reset_L;

  digit_scan_ctrl_if bus ();

  digit_scan_ctrl #(
    .PRESCALE(P),
    .CNT_W   (3)
  ) dut (
    .CLK    (CLK),
    .Reset_L(Reset_L),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model: cycles since reset release, plus the value/shadow state.
  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_sh;
  bit          m_pend;
  bit          m_fd;
  bit          m_ack;
  int          n_ack;
  int          n_fd;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)",
               tag, got, exp, t);
    end
  endtask

  task automatic m_reset();
    t      = 0;
    m_disp = 16'h0;
    m_sh   = 16'h0;
    m_pend = 0;
    m_fd   = 0;
    m_ack  = 0;
  endtask

  task automatic check_all(input string tag);
    int          s;
    logic [15:0] hi;
    logic [3:0]  nib;
    logic [6:0]  sg;
    s   = (t / P) % 4;
    hi  = m_disp >> (4 * s);
    nib = hi[3:0];
    sg  = SEG[nib];
    if (bus.blank_lz && s != 0 && hi == 16'h0)
      sg = 7'h00;
    chk({tag, ".sel"}, 16'(bus.sel), 16'(s));
    chk({tag, ".nib"}, 16'(bus.nibble), 16'(nib));
    chk({tag, ".seg"}, 16'(bus.seg), 16'(sg));
    chk({tag, ".fd"}, 16'(bus.frame_done), 16'(m_fd));
    chk({tag, ".ack"}, 16'(bus.load_ack), 16'(m_ack));
  endtask

  task automatic cyc(input bit ld, input logic [15:0] v);
    bit bnd;
    bus.load     = ld;
    bus.value_in = v;
    @(posedge CLK);
    if (Reset_L) begin
      bnd   = (t % FR == FR - 1);
      m_fd  = bnd;
      m_ack = bnd && m_pend;
      if (m_ack) begin
        m_disp = m_sh;
        m_pend = 0;
      end
      if (ld) begin
        m_sh   = v;
        m_pend = 1;
      end
      t++;
    end
    #1;
    check_all("cyc");
    if (bus.load_ack === 1'b1) n_ack++;
    if (bus.frame_done === 1'b1) n_fd++;
    bus.load = 1'b0;
  endtask

  task automatic run_until(input int ph);
    for (int i = 0; i < FR; i++) begin
      if (t % FR == ph) break;
      cyc(0, 16'h0);
    end
  endtask

  task automatic frame_expect(input string tag,
                              input logic [3:0] n [4],
                              input logic [6:0] g [4]);
    for (int d = 0; d < 4; d++) begin
      chk({tag, ".nib"}, 16'(bus.nibble), 16'(n[d]));
      chk({tag, ".seg"}, 16'(bus.seg), 16'(g[d]));
      for (int k = 0; k < P; k++) cyc(0, 16'h0);
    end
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.value_in = 16'h0;
    bus.blank_lz = 1'b0;
    Reset_L      = 1'b0;
    m_reset();
    n_ack = 0;
    n_fd  = 0;

    for (int i = 0; i < 3; i++) cyc(0, 16'h0);
    chk("rst.sel", 16'(bus.sel), 16'h0);
    chk("rst.seg", 16'(bus.seg), 16'h3F);
    #2 Reset_L = 1'b1;

    n_fd = 0;
    for (int i = 0; i < 2 * FR; i++) cyc(0, 16'h0);
    chk("fd_count", 16'(n_fd), 16'd2);

    // Load mid-frame, observe tear-free switch.
    run_until(5);
    cyc(1, 16'h1A2F);
    run_until(0);
    chk("ld.ack_fd", {14'h0, bus.load_ack, bus.frame_done}, 16'h3);
    frame_expect("ld1a2f", '{4'hF, 4'h2, 4'hA, 4'h1},
                 '{7'h71, 7'h5B, 7'h77, 7'h06});

    // Last load in a frame wins, single ack.
    n_ack = 0;
    run_until(3);
    cyc(1, 16'h1111);
    cyc(0, 16'h0);
    cyc(1, 16'h2222);
    for (int i = 0; i < 2 * FR; i++) cyc(0, 16'h0);
    chk("llw.acks", 16'(n_ack), 16'd1);
    run_until(0);
    frame_expect("llw", '{4'h2, 4'h2, 4'h2, 4'h2},
                 '{7'h5B, 7'h5B, 7'h5B, 7'h5B});

    // Load landing on the boundary edge.
    run_until(2);
    cyc(1, 16'h0000);
    run_until(0);
    run_until(4);
    cyc(1, 16'h00AB);
    run_until(FR - 1);
    cyc(1, 16'hCDEF);
    chk("bnd.ack1", 16'(bus.load_ack), 16'h1);
    chk("bnd.nib0", 16'(bus.nibble), 16'hB);
    run_until(FR - 1);
    cyc(0, 16'h0);
    chk("bnd.ack2", 16'(bus.load_ack), 16'h1);
    chk("bnd.nib0b", 16'(bus.nibble), 16'hF);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    run_until(6);
    cyc(1, 16'h0005);
    run_until(0);
    frame_expect("lz5", '{4'h5, 4'h0, 4'h0, 4'h0},
                 '{7'h6D, 7'h00, 7'h00, 7'h00});
    run_until(6);
    cyc(1, 16'h0000);
    run_until(0);
    frame_expect("lz0", '{4'h0, 4'h0, 4'h0, 4'h0},
                 '{7'h3F, 7'h00, 7'h00, 7'h00});
    bus.blank_lz = 1'b0;
    #1;
    frame_expect("nolz", '{4'h0, 4'h0, 4'h0, 4'h0},
                 '{7'h3F, 7'h3F, 7'h3F, 7'h3F});

    // Async reset with a pending load while sel=2.
    run_until(1);
    cyc(1, 16'hBEEF);
    run_until(9);
    #2 Reset_L = 1'b0;
    m_reset();
    #1;
    chk("mrst.sel", 16'(bus.sel), 16'h0);
    chk("mrst.nib", 16'(bus.nibble), 16'h0);
    chk("mrst.ack", 16'(bus.load_ack), 16'h0);
    cyc(0, 16'h0);
    cyc(0, 16'h0);
    #2 Reset_L = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 3 * FR; i++) cyc(0, 16'h0);
    chk("mrst.acks", 16'(n_ack), 16'd0);
    chk("mrst.nibq", 16'(bus.nibble), 16'h0);

    // Random loads and blanking changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0)
        bus.blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0)
          cyc(1, 16'($urandom_range(0, 255)));
        else
          cyc(1, 16'($urandom));
      end else begin
        cyc(0, 16'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
